event_header_reader: RTL and testbench

- Read side of the per-buffer event header RAM.
- Upstream, the event generator writes the 22-word header (offsets 0x00–0x15) at address {buffer[1:0], offset[5:0]} and signals completion when its write strobe falls.
- This block queues the completed buffer numbers, reads each header out in offset order, and streams it to the host readout with a valid/ready handshake.
- When a header has been fully consumed, it issues a buffer-clear pulse so the buffer can be re-armed.

---
 rtl/event_hdr_pkg.sv | 32 +++
 rtl/hdr_buf_queue.sv | 65 ++++++
 rtl/event_header_reader.sv | 167 ++++++++++++++++
 tb/tb_event_header_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_hdr_pkg.sv
// ---------------------------------------------------------------------------
// event_hdr_pkg
// Shared definitions for the event header read side: default header length,
// the word offsets of the named header fields, and the readout FSM state
// encoding used by event_header_reader.
// ---------------------------------------------------------------------------
package event_hdr_pkg;

  localparam int HDR_WORDS_DEFAULT = 22;

  // Named header word offsets inside one buffer's header region
  localparam logic [5:0] HDR_SRC    = 6'h00;
  localparam logic [5:0] HDR_COUNT  = 6'h01;
  localparam logic [5:0] HDR_CLK_LO = 6'h02;
  localparam logic [5:0] HDR_CLK_HI = 6'h03;
  localparam logic [5:0] HDR_PPS    = 6'h04;
  localparam logic [5:0] HDR_VPHI   = 6'h06;
  localparam logic [5:0] HDR_HPHI   = 6'h07;
  localparam logic [5:0] HDR_ID_LO  = 6'h10;
  localparam logic [5:0] HDR_ID_HI  = 6'h11;
  localparam logic [5:0] HDR_LABID  = 6'h14;
  localparam logic [5:0] HDR_HOLDS  = 6'h15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_CLEAR   = 3'd4
  } hdr_state_t;

endpackage

// File: rtl/hdr_buf_queue.sv
// ---------------------------------------------------------------------------
// hdr_buf_queue
// Small synchronous FIFO holding the numbers of buffers whose headers are
// complete and waiting to be read out.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, push_dat : enqueue request and value (ignored when full unless a
//                    pop happens in the same cycle)
//   pop, pop_dat   : dequeue request; pop_dat shows the head entry
//   count          : registered number of stored entries
//   full, empty    : occupancy flags
// DEPTH must be a power of 2 (pointers wrap naturally), at least 2.
// ---------------------------------------------------------------------------
module hdr_buf_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // A push into a full queue is still accepted when the head leaves in the
  // same cycle, since the slot being written is the one just freed.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/event_header_reader.sv
// ---------------------------------------------------------------------------
// event_header_reader
// Read side of the per-buffer event header RAM. Completed buffers (falling
// edge of the event generator's write strobe) are queued; each queued header
// is read word by word from the RAM and streamed to the host over a
// valid/ready handshake, followed by a one-cycle buffer-clear pulse.
//   clk33_i, rst_n_i        : readout clock, async active-low reset
//   event_wr_i              : generator write strobe (fall = header complete)
//   event_buffer_i          : buffer number, sampled while event_wr_i=1
//   ram_addr_o, ram_rd_o    : header RAM read port ({buffer, offset})
//   ram_dat_i               : RAM data, one cycle after ram_rd_o
//   hdr_dat_o/valid/last    : header word stream to the host
//   hdr_ready_i             : host accepts the presented word
//   buf_clear_o/_buf_o      : re-arm pulse and the buffer it applies to
//   pending_o               : queued headers not yet started
//   overflow_o              : sticky, a completion was lost to a full queue
// ---------------------------------------------------------------------------
module event_header_reader
  import event_hdr_pkg::*;
#(
  parameter int HDR_WORDS   = HDR_WORDS_DEFAULT,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        event_wr_i,
  input  logic [1:0]  event_buffer_i,
  output logic [7:0]  ram_addr_o,
  output logic        ram_rd_o,
  input  logic [15:0] ram_dat_i,
  output logic [15:0] hdr_dat_o,
  output logic        hdr_valid_o,
  output logic        hdr_last_o,
  input  logic        hdr_ready_i,
  output logic        buf_clear_o,
  output logic [1:0]  buf_clear_buf_o,
  output logic [2:0]  pending_o,
  output logic        overflow_o
);

  localparam int         CNT_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [5:0] LAST_OFF = 6'(HDR_WORDS - 1);

  hdr_state_t       state;
  hdr_state_t       state_nxt;
  logic             wr_d;
  logic [1:0]       buf_d;
  logic             push_q;
  logic             pop;
  logic [1:0]       q_head;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic [1:0]       cur_buf;
  logic [5:0]       offset;

  // Completion detect: the strobe history starts at 0 out of reset so a strobe
  // held through reset cannot look like a fall. The push is registered, so it
  // lands in the queue one cycle after the fall is seen.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_d   <= 1'b0;
      buf_d  <= 2'b00;
      push_q <= 1'b0;
    end else begin
      wr_d   <= event_wr_i;
      if (event_wr_i) buf_d <= event_buffer_i;
      push_q <= wr_d & ~event_wr_i;
    end
  end

  hdr_buf_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (2)
  ) u_queue (
    .clk      (clk33_i),
    .rst_n    (rst_n_i),
    .push     (push_q),
    .push_dat (buf_d),
    .pop      (pop),
    .pop_dat  (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign pending_o = 3'(q_count);

  // Overflow only when the push is actually dropped: full with no pop this cycle
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) overflow_o <= 1'b0;
    else if (push_q && q_full && !pop) overflow_o <= 1'b1;
  end

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    ram_rd_o    = 1'b0;
    buf_clear_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ram_rd_o  = 1'b1;
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (hdr_ready_i) state_nxt = hdr_last_o ? ST_CLEAR : ST_ISSUE;
      end
      ST_CLEAR: begin
        buf_clear_o = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The address is formed from the registered buffer/offset pair, so it only
  // moves when a new header starts or the word loop advances.
  assign ram_addr_o      = {cur_buf, offset};
  assign buf_clear_buf_o = buf_clear_o ? cur_buf : 2'b00;

  // Word datapath: capture the RAM word the cycle its data is valid and hold
  // it until the host accepts; the offset never passes LAST_OFF.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_buf     <= 2'b00;
      offset      <= 6'd0;
      hdr_dat_o   <= 16'h0000;
      hdr_valid_o <= 1'b0;
      hdr_last_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            cur_buf <= q_head;
            offset  <= 6'd0;
          end
        end
        ST_CAPTURE: begin
          hdr_dat_o   <= ram_dat_i;
          hdr_valid_o <= 1'b1;
          hdr_last_o  <= (offset == LAST_OFF);
        end
        ST_PRESENT: begin
          if (hdr_ready_i) begin
            hdr_valid_o <= 1'b0;
            hdr_last_o  <= 1'b0;
            if (!hdr_last_o) offset <= offset + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_event_header_reader.sv
// ---------------------------------------------------------------------------
// tb_event_header_reader
// Scoreboard bench for event_header_reader: each completed header pushes its
// expected words and clear into queues, which a negedge monitor pops as the
// design emits them. A small RAM model answers reads one cycle later.
// ---------------------------------------------------------------------------
module tb_event_header_reader;

  localparam int HDR_WORDS = 22;

  typedef struct packed {
    logic [15:0] dat;
    logic        last;
  } exp_word_t;

  logic        clk33 = 1'b0;
  logic        rst_n;
  logic        event_wr;
  logic [1:0]  event_buffer;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [15:0] ram_dat;
  logic [15:0] hdr_dat;
  logic        hdr_valid;
  logic        hdr_last;
  logic        hdr_ready;
  logic        buf_clear;
  logic [1:0]  buf_clear_buf;
  logic [2:0]  pending;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int clear_count = 0;
  int words_seen = 0;

  exp_word_t  exp_q[$];
  logic [1:0] exp_clr[$];

  always #15 clk33 = ~clk33;

  event_header_reader #(
    .HDR_WORDS   (HDR_WORDS),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk33_i         (clk33),
    .rst_n_i         (rst_n),
    .event_wr_i      (event_wr),
    .event_buffer_i  (event_buffer),
    .ram_addr_o      (ram_addr),
    .ram_rd_o        (ram_rd),
    .ram_dat_i       (ram_dat),
    .hdr_dat_o       (hdr_dat),
    .hdr_valid_o     (hdr_valid),
    .hdr_last_o      (hdr_last),
    .hdr_ready_i     (hdr_ready),
    .buf_clear_o     (buf_clear),
    .buf_clear_buf_o (buf_clear_buf),
    .pending_o       (pending),
    .overflow_o      (overflow)
  );

  // Header RAM contents: buffer 2 holds 0x1000+offset, other buffers get a
  // distinct high byte so a wrong buffer select is visible.
  function automatic logic [15:0] ramWord(input logic [7:0] a);
    logic [1:0] b;
    b = a[7:6] ^ 2'd2;
    return 16'h1000 + {10'd0, a[5:0]} + {6'd0, b, 8'h00};
  endfunction

  // Read data is only meaningful one cycle after a read strobe
  always_ff @(posedge clk33) begin
    ram_dat <= ram_rd ? ramWord(ram_addr) : 16'hDEAD;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk33);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] b);
    event_wr     = wr;
    event_buffer = b;
  endtask

  task automatic pushExpected(input logic [1:0] b);
    exp_word_t w;
    for (int k = 0; k < HDR_WORDS; k++) begin
      w.dat  = ramWord({b, 6'(k)});
      w.last = (k == HDR_WORDS - 1);
      exp_q.push_back(w);
    end
    exp_clr.push_back(b);
  endtask

  // Strobe high for hi cycles then low; returns just after the fall is driven
  task automatic sendEvent(input logic [1:0] b, input int hi, input bit queued);
    tick();
    applyStimulus(1'b1, b);
    repeat (hi) tick();
    applyStimulus(1'b0, b);
    if (queued) pushExpected(b);
  endtask

  task automatic waitDrain(input bit rnd_ready, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rnd_ready) hdr_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && exp_clr.size() == 0) break;
    end
    hdr_ready = 1'b1;
    checkOutput("drain_left", 32'(exp_q.size() + exp_clr.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic runMonitor();
    bit          prev_hold = 1'b0;
    logic [15:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    exp_word_t   w;
    forever begin
      @(negedge clk33);
      if (prev_hold) begin
        checkOutput("stable_valid", 32'(hdr_valid), 32'd1);
        checkOutput("stable_dat", 32'(hdr_dat), 32'(prev_dat));
        checkOutput("stable_last", 32'(hdr_last), 32'(prev_last));
      end
      if (hdr_valid && hdr_ready) begin
        words_seen++;
        checkOutput("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          checkOutput("word_dat", 32'(hdr_dat), 32'(w.dat));
          checkOutput("word_last", 32'(hdr_last), 32'(w.last));
        end
      end
      if (buf_clear) begin
        clear_count++;
        checkOutput("clr_expected", 32'(exp_clr.size() != 0), 32'd1);
        if (exp_clr.size() != 0) checkOutput("clr_buf", 32'(buf_clear_buf), 32'(exp_clr.pop_front()));
      end
      prev_hold = rst_n && hdr_valid && !hdr_ready;
      prev_dat  = hdr_dat;
      prev_last = hdr_last;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(hdr_valid), 32'd0);
    checkOutput({tag, "_dat"}, 32'(hdr_dat), 32'd0);
    checkOutput({tag, "_last"}, 32'(hdr_last), 32'd0);
    checkOutput({tag, "_rd"}, 32'(ram_rd), 32'd0);
    checkOutput({tag, "_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_clr"}, 32'(buf_clear), 32'd0);
    checkOutput({tag, "_clrbuf"}, 32'(buf_clear_buf), 32'd0);
    checkOutput({tag, "_pending"}, 32'(pending), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int lat;
    int clr_base;
    int word_base;
    bit found;

    rst_n = 1'b0;
    hdr_ready = 1'b1;
    applyStimulus(1'b0, 2'd0);
    fork
      runMonitor();
    join_none
    repeat (3) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single header from buffer 2, host always ready, latency from the fall
    $display("[TB] test 1: single header");
    sendEvent(2'd2, 10, 1'b1);
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hdr_valid) begin
        found = 1'b1;
        break;
      end
      lat++;
    end
    checkOutput("first_valid_seen", 32'(found), 32'd1);
    checkOutput("latency", 32'(lat), 32'd4);
    waitDrain(1'b0, 200);

    // 2: same header under random backpressure
    $display("[TB] test 2: backpressure");
    clr_base = clear_count;
    sendEvent(2'd2, 10, 1'b1);
    waitDrain(1'b1, 1000);
    checkOutput("bp_clears", 32'(clear_count - clr_base), 32'd1);

    // 3: three completions queued behind the one being read
    $display("[TB] test 3: back-to-back completions");
    clr_base = clear_count;
    sendEvent(2'd0, 2, 1'b1);
    repeat (3) tick();
    sendEvent(2'd1, 1, 1'b1);
    sendEvent(2'd2, 1, 1'b1);
    sendEvent(2'd3, 1, 1'b1);
    repeat (2) tick();
    checkOutput("pending_peak", 32'(pending), 32'd3);
    waitDrain(1'b0, 600);
    checkOutput("multi_clears", 32'(clear_count - clr_base), 32'd4);
    checkOutput("multi_ovf", 32'(overflow), 32'd0);

    // 5: a push landing in the same cycle as the IDLE pop
    $display("[TB] test 5: simultaneous push and pop");
    sendEvent(2'd1, 2, 1'b1);
    repeat (5) tick();
    sendEvent(2'd2, 2, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hdr_valid && hdr_last) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("last_seen", 32'(found), 32'd1);
    applyStimulus(1'b1, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd3);
    pushExpected(2'd3);
    tick();
    checkOutput("pend_before_pop", 32'(pending), 32'd1);
    tick();
    checkOutput("pend_push_pop", 32'(pending), 32'd1);
    waitDrain(1'b0, 400);

    // 4: host stalled, six completions: one in service, four queued, one lost
    $display("[TB] test 4: overflow");
    hdr_ready = 1'b0;
    for (int i = 0; i < 5; i++) sendEvent(2'(i), 1, 1'b1);
    repeat (2) tick();
    checkOutput("full_pending", 32'(pending), 32'd4);
    checkOutput("ovf_before", 32'(overflow), 32'd0);
    sendEvent(2'd1, 1, 1'b0);
    repeat (2) tick();
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_pending", 32'(pending), 32'd4);
    hdr_ready = 1'b1;
    waitDrain(1'b0, 800);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("ovf_drained", 32'(pending), 32'd0);

    // 6: reset in the middle of a header while the strobe is high
    $display("[TB] test 6: reset mid-header");
    word_base = words_seen;
    sendEvent(2'd1, 2, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (words_seen - word_base >= 10) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach_offset10", 32'(found), 32'd1);
    applyStimulus(1'b1, 2'd2);
    #5;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    exp_q.delete();
    exp_clr.delete();
    tick();
    applyStimulus(1'b0, 2'd2);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("post_rst_pending", 32'(pending), 32'd0);
    checkOutput("post_rst_valid", 32'(hdr_valid), 32'd0);
    checkOutput("post_rst_words", 32'(words_seen - word_base), 32'd10);
    sendEvent(2'd3, 3, 1'b1);
    waitDrain(1'b0, 200);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
